// File: rtl/id_pipe.sv
// id_pipe: MIPS32-subset decode stage. Decodes the instruction in IF, reads two
// register-file ports, forwards from EX/MEM, stalls on load-use hazards and
// holds its results in an ID/EX register under valid/ready handshaking.

`ifndef ID_PIPE_DEFS_SV
`define ID_PIPE_DEFS_SV
`define AluOpBus       7:0
`define AluSelBus      2:0
`define EXE_OP_NOP     8'h00
`define EXE_OP_AND     8'h24
`define EXE_OP_OR      8'h25
`define EXE_OP_XOR     8'h26
`define EXE_OP_SLT     8'h2a
`define EXE_OP_SLL     8'h7c
`define EXE_OP_SRL     8'h02
`define EXE_OP_ADDU    8'h21
`define EXE_OP_SUBU    8'h23
`define EXE_OP_LW      8'he3
`define EXE_SEL_NOP    3'b000
`define EXE_SEL_LOGIC  3'b001
`define EXE_SEL_SHIFT  3'b010
`define EXE_SEL_ARITH  3'b100
`define EXE_SEL_LOAD   3'b111
`endif

module id_pipe #(
    parameter int DATA_W  = 32,
    parameter int IADDR_W = 32,
    parameter int RADDR_W = 5,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               if_valid_i,
    input  logic [IADDR_W-1:0] pc_i,
    input  logic [31:0]        inst_i,
    output logic               id_ready_o,
    output logic               reg0_re_o,
    output logic [RADDR_W-1:0] reg0_addr_o,
    input  logic [DATA_W-1:0]  reg0_data_i,
    output logic               reg1_re_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    input  logic [DATA_W-1:0]  reg1_data_i,
    input  logic               ex_we_i,
    input  logic [RADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_we_i,
    input  logic [RADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [`AluOpBus]   aluop_o,
    output logic [`AluSelBus]  alusel_o,
    output logic [DATA_W-1:0]  reg0_o,
    output logic [DATA_W-1:0]  reg1_o,
    output logic [RADDR_W-1:0] waddr_o,
    output logic               we_o,
    output logic               is_load_o,
    output logic [IADDR_W-1:0] pc_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_ANDI    = 6'h0c;
    localparam logic [5:0] OPC_ORI     = 6'h0d;
    localparam logic [5:0] OPC_XORI    = 6'h0e;
    localparam logic [5:0] OPC_LUI     = 6'h0f;
    localparam logic [5:0] OPC_LW      = 6'h23;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    logic [5:0]         opc;
    logic [5:0]         funct;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;

    logic [`AluOpBus]   d_op;
    logic [`AluSelBus]  d_sel;
    logic               d_re0;
    logic               d_re1;
    logic [DATA_W-1:0]  d_imm0;
    logic [DATA_W-1:0]  d_imm1;
    logic [RADDR_W-1:0] d_waddr;
    logic               d_we;
    logic               d_load;
    logic               d_illegal;

    logic [DATA_W-1:0]  opnd0;
    logic [DATA_W-1:0]  opnd1;
    logic               src_ex;
    logic               src_mem;
    logic               hz;
    logic               adv;

    assign opc   = inst_i[31:26];
    assign funct = inst_i[5:0];
    assign rs    = RADDR_W'(inst_i[25:21]);
    assign rt    = RADDR_W'(inst_i[20:16]);
    assign rd    = RADDR_W'(inst_i[15:11]);

    assign reg0_addr_o = rs;
    assign reg1_addr_o = rt;
    assign reg0_re_o   = d_re0;
    assign reg1_re_o   = d_re1;

    // Instruction decode into ALU op/select, read enables, immediates and destination.
    always_comb begin
        d_op      = `EXE_OP_NOP;
        d_sel     = `EXE_SEL_NOP;
        d_re0     = 1'b0;
        d_re1     = 1'b0;
        d_imm0    = '0;
        d_imm1    = '0;
        d_waddr   = '0;
        d_we      = 1'b0;
        d_load    = 1'b0;
        d_illegal = 1'b0;
        if (inst_i != 32'h0000_0000) begin
            case (opc)
                OPC_SPECIAL: begin
                    d_re0   = 1'b1;
                    d_re1   = 1'b1;
                    d_waddr = rd;
                    d_we    = 1'b1;
                    case (funct)
                        FN_ADDU: begin d_op = `EXE_OP_ADDU; d_sel = `EXE_SEL_ARITH; end
                        FN_SUBU: begin d_op = `EXE_OP_SUBU; d_sel = `EXE_SEL_ARITH; end
                        FN_SLT:  begin d_op = `EXE_OP_SLT;  d_sel = `EXE_SEL_ARITH; end
                        FN_AND:  begin d_op = `EXE_OP_AND;  d_sel = `EXE_SEL_LOGIC; end
                        FN_OR:   begin d_op = `EXE_OP_OR;   d_sel = `EXE_SEL_LOGIC; end
                        FN_XOR:  begin d_op = `EXE_OP_XOR;  d_sel = `EXE_SEL_LOGIC; end
                        FN_SLL, FN_SRL: begin
                            d_op   = (funct == FN_SLL) ? `EXE_OP_SLL : `EXE_OP_SRL;
                            d_sel  = `EXE_SEL_SHIFT;
                            d_re0  = 1'b0;
                            d_imm0 = DATA_W'(inst_i[10:6]);
                        end
                        default: begin
                            d_re0     = 1'b0;
                            d_re1     = 1'b0;
                            d_waddr   = '0;
                            d_we      = 1'b0;
                            d_illegal = 1'b1;
                        end
                    endcase
                end
                OPC_ORI, OPC_ANDI, OPC_XORI, OPC_ADDIU, OPC_LUI, OPC_LW: begin
                    d_re0   = (opc != OPC_LUI);
                    d_waddr = rt;
                    d_we    = 1'b1;
                    case (opc)
                        OPC_ORI: begin
                            d_op = `EXE_OP_OR;  d_sel = `EXE_SEL_LOGIC;
                            d_imm1 = DATA_W'(inst_i[15:0]);
                        end
                        OPC_ANDI: begin
                            d_op = `EXE_OP_AND; d_sel = `EXE_SEL_LOGIC;
                            d_imm1 = DATA_W'(inst_i[15:0]);
                        end
                        OPC_XORI: begin
                            d_op = `EXE_OP_XOR; d_sel = `EXE_SEL_LOGIC;
                            d_imm1 = DATA_W'(inst_i[15:0]);
                        end
                        OPC_ADDIU: begin
                            d_op = `EXE_OP_ADDU; d_sel = `EXE_SEL_ARITH;
                            d_imm1 = DATA_W'($signed(inst_i[15:0]));
                        end
                        OPC_LUI: begin
                            // LUI is executed as 0 | (imm << 16)
                            d_op = `EXE_OP_OR;  d_sel = `EXE_SEL_LOGIC;
                            d_imm1 = DATA_W'({inst_i[15:0], 16'h0000});
                        end
                        default: begin
                            d_op = `EXE_OP_LW;  d_sel = `EXE_SEL_LOAD;
                            d_imm1 = DATA_W'($signed(inst_i[15:0]));
                            d_load = 1'b1;
                        end
                    endcase
                end
                default: d_illegal = 1'b1;
            endcase
        end
    end

    // Operand select: immediate/shamt, $zero, EX forward, MEM forward, register file.
    always_comb begin
        if (!d_re0)
            opnd0 = d_imm0;
        else if (rs == '0)
            opnd0 = '0;
        else if ((FWD_EN != 0) && ex_we_i && (ex_waddr_i == rs))
            opnd0 = ex_wdata_i;
        else if ((FWD_EN != 0) && mem_we_i && (mem_waddr_i == rs))
            opnd0 = mem_wdata_i;
        else
            opnd0 = reg0_data_i;

        if (!d_re1)
            opnd1 = d_imm1;
        else if (rt == '0)
            opnd1 = '0;
        else if ((FWD_EN != 0) && ex_we_i && (ex_waddr_i == rt))
            opnd1 = ex_wdata_i;
        else if ((FWD_EN != 0) && mem_we_i && (mem_waddr_i == rt))
            opnd1 = mem_wdata_i;
        else
            opnd1 = reg1_data_i;
    end

    // Hazard detection: a load in EX cannot be forwarded; without forwarding any pending write stalls.
    always_comb begin
        src_ex  = ex_we_i && (ex_waddr_i != '0) &&
                  ((d_re0 && (ex_waddr_i == rs)) || (d_re1 && (ex_waddr_i == rt)));
        src_mem = mem_we_i && (mem_waddr_i != '0) &&
                  ((d_re0 && (mem_waddr_i == rs)) || (d_re1 && (mem_waddr_i == rt)));
        if (FWD_EN != 0)
            hz = if_valid_i && ex_is_load_i && src_ex;
        else
            hz = if_valid_i && (src_ex || src_mem);
        adv        = !ex_valid_o || ex_ready_i;
        id_ready_o = (adv && !hz) || flush_i;
    end

    // ID/EX register and stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_o  <= 1'b0;
            aluop_o     <= `EXE_OP_NOP;
            alusel_o    <= `EXE_SEL_NOP;
            reg0_o      <= '0;
            reg1_o      <= '0;
            waddr_o     <= '0;
            we_o        <= 1'b0;
            is_load_o   <= 1'b0;
            pc_o        <= '0;
            illegal_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else if (flush_i || (adv && (hz || !if_valid_i))) begin
            ex_valid_o <= 1'b0;
            aluop_o    <= `EXE_OP_NOP;
            alusel_o   <= `EXE_SEL_NOP;
            we_o       <= 1'b0;
            is_load_o  <= 1'b0;
            illegal_o  <= 1'b0;
            if (!flush_i && hz && (stall_cnt_o != {CNT_W{1'b1}}))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end else if (adv) begin
            ex_valid_o <= 1'b1;
            aluop_o    <= d_op;
            alusel_o   <= d_sel;
            reg0_o     <= opnd0;
            reg1_o     <= opnd1;
            waddr_o    <= d_waddr;
            we_o       <= d_we;
            is_load_o  <= d_load;
            pc_o       <= pc_i;
            illegal_o  <= d_illegal;
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: table-driven decode vectors, hand-written multi-cycle sequences,
// then randomized traffic compared against a transaction-level model.

module tb_id_pipe;

    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26,
                           OP_SLT = 8'h2a, OP_SLL = 8'h7c, OP_SRL = 8'h02, OP_ADDU = 8'h21,
                           OP_SUBU = 8'h23, OP_LW = 8'he3;
    localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010,
                           SEL_ARITH = 3'b100, SEL_LOAD = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        flush, if_valid, ex_we, ex_is_load, mem_we, ex_ready;
    logic [31:0] pc, inst, ex_wdata, mem_wdata;
    logic [4:0]  ex_waddr, mem_waddr;
    logic [31:0] rf [32];

    logic        a_ready, a_re0, a_re1, a_valid, a_we, a_ld, a_ill;
    logic [4:0]  a_addr0, a_addr1, a_wa;
    logic [31:0] a_rd0, a_rd1, a_r0, a_r1, a_pc;
    logic [7:0]  a_op;
    logic [2:0]  a_sel;
    logic [15:0] a_cnt;

    logic        b_ready, b_re0, b_re1, b_valid, b_we, b_ld, b_ill;
    logic [4:0]  b_addr0, b_addr1, b_wa;
    logic [31:0] b_rd0, b_rd1, b_r0, b_r1, b_pc;
    logic [7:0]  b_op;
    logic [2:0]  b_sel;
    logic [1:0]  b_cnt;

    assign a_rd0 = rf[a_addr0];
    assign a_rd1 = rf[a_addr1];
    assign b_rd0 = rf[b_addr0];
    assign b_rd1 = rf[b_addr1];

    id_pipe #(.DATA_W(32), .IADDR_W(32), .RADDR_W(5), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .pc_i(pc), .inst_i(inst),
        .id_ready_o(a_ready), .reg0_re_o(a_re0), .reg0_addr_o(a_addr0), .reg0_data_i(a_rd0),
        .reg1_re_o(a_re1), .reg1_addr_o(a_addr1), .reg1_data_i(a_rd1),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .ex_valid_o(a_valid), .ex_ready_i(ex_ready), .aluop_o(a_op), .alusel_o(a_sel),
        .reg0_o(a_r0), .reg1_o(a_r1), .waddr_o(a_wa), .we_o(a_we), .is_load_o(a_ld),
        .pc_o(a_pc), .illegal_o(a_ill), .stall_cnt_o(a_cnt));

    id_pipe #(.DATA_W(32), .IADDR_W(32), .RADDR_W(5), .FWD_EN(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(if_valid), .pc_i(pc), .inst_i(inst),
        .id_ready_o(b_ready), .reg0_re_o(b_re0), .reg0_addr_o(b_addr0), .reg0_data_i(b_rd0),
        .reg1_re_o(b_re1), .reg1_addr_o(b_addr1), .reg1_data_i(b_rd1),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .ex_valid_o(b_valid), .ex_ready_i(ex_ready), .aluop_o(b_op), .alusel_o(b_sel),
        .reg0_o(b_r0), .reg1_o(b_r1), .waddr_o(b_wa), .we_o(b_we), .is_load_o(b_ld),
        .pc_o(b_pc), .illegal_o(b_ill), .stall_cnt_o(b_cnt));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        bit          re0, re1;
        logic [31:0] i0, i1;
        logic [4:0]  wa;
        bit          we, ld, ill;
    } dec_t;

    typedef struct {
        bit          valid;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r0, r1, pc;
        logic [4:0]  wa;
        bit          we, ld, ill;
        int          cnt;
    } mstate_t;

    mstate_t ma, mb;
    bit last_ready_a, last_ready_b;

    function automatic dec_t m_decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0]  opc, fn;
        logic [15:0] imm;
        opc = ins[31:26]; fn = ins[5:0]; imm = ins[15:0];
        d.op = OP_NOP; d.sel = SEL_NOP; d.re0 = 0; d.re1 = 0; d.i0 = 0; d.i1 = 0;
        d.wa = 0; d.we = 0; d.ld = 0; d.ill = 0;
        if (ins == 32'h0) return d;
        if (opc == 6'h00) begin
            bit known = 1;
            case (fn)
                6'h21: begin d.op = OP_ADDU; d.sel = SEL_ARITH; end
                6'h23: begin d.op = OP_SUBU; d.sel = SEL_ARITH; end
                6'h2a: begin d.op = OP_SLT;  d.sel = SEL_ARITH; end
                6'h24: begin d.op = OP_AND;  d.sel = SEL_LOGIC; end
                6'h25: begin d.op = OP_OR;   d.sel = SEL_LOGIC; end
                6'h26: begin d.op = OP_XOR;  d.sel = SEL_LOGIC; end
                6'h00: begin d.op = OP_SLL;  d.sel = SEL_SHIFT; end
                6'h02: begin d.op = OP_SRL;  d.sel = SEL_SHIFT; end
                default: known = 0;
            endcase
            if (!known) begin d.ill = 1; return d; end
            d.re1 = 1; d.wa = ins[15:11]; d.we = 1;
            if (d.sel == SEL_SHIFT) d.i0 = {27'd0, ins[10:6]};
            else d.re0 = 1;
            return d;
        end
        d.wa = ins[20:16]; d.we = 1; d.re0 = 1;
        case (opc)
            6'h0d: begin d.op = OP_OR;   d.sel = SEL_LOGIC; d.i1 = {16'h0, imm}; end
            6'h0c: begin d.op = OP_AND;  d.sel = SEL_LOGIC; d.i1 = {16'h0, imm}; end
            6'h0e: begin d.op = OP_XOR;  d.sel = SEL_LOGIC; d.i1 = {16'h0, imm}; end
            6'h09: begin d.op = OP_ADDU; d.sel = SEL_ARITH; d.i1 = {{16{imm[15]}}, imm}; end
            6'h0f: begin d.op = OP_OR;   d.sel = SEL_LOGIC; d.i1 = {imm, 16'h0}; d.re0 = 0; end
            6'h23: begin d.op = OP_LW;   d.sel = SEL_LOAD;  d.i1 = {{16{imm[15]}}, imm}; d.ld = 1; end
            default: begin
                d.wa = 0; d.we = 0; d.re0 = 0; d.ill = 1;
            end
        endcase
        return d;
    endfunction

    function automatic logic [31:0] m_operand(input bit fwd, input bit re, input logic [4:0] a,
                                              input logic [31:0] imm);
        if (!re) return imm;
        if (a == 0) return 32'h0;
        if (fwd && ex_we && ex_waddr == a) return ex_wdata;
        if (fwd && mem_we && mem_waddr == a) return mem_wdata;
        return rf[a];
    endfunction

    function automatic bit m_hazard(input bit fwd, input dec_t d);
        logic [4:0] srcs[$];
        bit hit_ex, hit_mem;
        hit_ex = 0; hit_mem = 0;
        if (d.re0 && inst[25:21] != 0) srcs.push_back(inst[25:21]);
        if (d.re1 && inst[20:16] != 0) srcs.push_back(inst[20:16]);
        foreach (srcs[i]) begin
            if (ex_we && ex_waddr == srcs[i]) hit_ex = 1;
            if (mem_we && mem_waddr == srcs[i]) hit_mem = 1;
        end
        if (!if_valid) return 0;
        return fwd ? (ex_is_load && hit_ex) : (hit_ex || hit_mem);
    endfunction

    task automatic m_step(input bit fwd, input int cmax, input mstate_t s, output mstate_t n,
                          output bit ready);
        dec_t d;
        bit hz, adv;
        d = m_decode(inst);
        hz = m_hazard(fwd, d);
        adv = !s.valid || ex_ready;
        ready = (adv && !hz) || flush;
        n = s;
        if (flush || (adv && (hz || !if_valid))) begin
            n.valid = 0; n.op = OP_NOP; n.sel = SEL_NOP; n.we = 0;
            if (!flush && hz && n.cnt < cmax) n.cnt++;
        end else if (adv) begin
            n.valid = 1; n.op = d.op; n.sel = d.sel; n.we = d.we; n.ld = d.ld; n.ill = d.ill;
            n.wa = d.wa; n.pc = pc;
            n.r0 = m_operand(fwd, d.re0, inst[25:21], d.i0);
            n.r1 = m_operand(fwd, d.re1, inst[20:16], d.i1);
        end
    endtask

    task automatic m_reset();
        ma.valid = 0; ma.op = OP_NOP; ma.sel = SEL_NOP; ma.r0 = 0; ma.r1 = 0; ma.pc = 0;
        ma.wa = 0; ma.we = 0; ma.ld = 0; ma.ill = 0; ma.cnt = 0;
        mb = ma;
    endtask

    task automatic cmp_state(input string t, input mstate_t m, input logic v, input logic [7:0] op,
                             input logic [2:0] sel, input logic [31:0] r0, input logic [31:0] r1,
                             input logic [4:0] wa, input logic we, input logic ld,
                             input logic [31:0] p, input logic ill, input logic [15:0] cnt);
        chk({t, ".ex_valid"}, v, m.valid);
        chk({t, ".aluop"}, op, m.op);
        chk({t, ".alusel"}, sel, m.sel);
        chk({t, ".we"}, we, m.we);
        chk({t, ".stall_cnt"}, cnt, 64'(m.cnt));
        if (m.valid) begin
            chk({t, ".reg0"}, r0, m.r0);
            chk({t, ".reg1"}, r1, m.r1);
            chk({t, ".waddr"}, wa, m.wa);
            chk({t, ".is_load"}, ld, m.ld);
            chk({t, ".illegal"}, ill, m.ill);
            chk({t, ".pc"}, p, m.pc);
        end
    endtask

    // One clock: called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle(input bit do_check);
        mstate_t na, nb;
        dec_t d;
        bit ra, rb;
        #3;
        m_step(1'b1, 65535, ma, na, ra);
        m_step(1'b0, 3, mb, nb, rb);
        last_ready_a = a_ready;
        last_ready_b = b_ready;
        if (do_check) begin
            d = m_decode(inst);
            chk("A.id_ready", a_ready, ra);
            chk("B.id_ready", b_ready, rb);
            chk("A.reg0_re", a_re0, d.re0);
            chk("A.reg1_re", a_re1, d.re1);
            chk("A.reg0_addr", a_addr0, inst[25:21]);
            chk("A.reg1_addr", a_addr1, inst[20:16]);
        end
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        if (do_check) begin
            cmp_state("A", ma, a_valid, a_op, a_sel, a_r0, a_r1, a_wa, a_we, a_ld, a_pc, a_ill, a_cnt);
            cmp_state("B", mb, b_valid, b_op, b_sel, b_r0, b_r1, b_wa, b_we, b_ld, b_pc, b_ill,
                      16'(b_cnt));
        end
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, ".ex_valid"}, a_valid, 0);
        chk({t, ".aluop"}, a_op, OP_NOP);
        chk({t, ".alusel"}, a_sel, SEL_NOP);
        chk({t, ".reg0"}, a_r0, 0);
        chk({t, ".reg1"}, a_r1, 0);
        chk({t, ".waddr"}, a_wa, 0);
        chk({t, ".we"}, a_we, 0);
        chk({t, ".is_load"}, a_ld, 0);
        chk({t, ".pc"}, a_pc, 0);
        chk({t, ".illegal"}, a_ill, 0);
        chk({t, ".stall_cnt"}, a_cnt, 0);
        chk({t, ".b_stall_cnt"}, b_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_reset();
    endtask

    task automatic clear_side();
        flush = 0; ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0; ex_ready = 1; if_valid = 1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3)); sa = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 16))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
            5:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
            6:  return {6'h00, 5'd0, rt, rd, sa, 6'h00};
            7:  return {6'h00, 5'd0, rt, rd, sa, 6'h02};
            8:  return {6'h0d, rs, rt, imm};
            9:  return {6'h0c, rs, rt, imm};
            10: return {6'h0e, rs, rt, imm};
            11: return {6'h09, rs, rt, imm};
            12: return {6'h0f, 5'd0, rt, imm};
            13: return {6'h23, rs, rt, imm};
            14: return {6'h3f, rs, rt, imm};
            15: return 32'h0;
            default: return {6'h00, rs, rt, rd, 5'd0, 6'h3f};
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        ex_we;
        logic [4:0]  ex_waddr;
        logic [31:0] ex_wdata;
        logic        mem_we;
        logic [4:0]  mem_waddr;
        logic [31:0] mem_wdata;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r0, r1;
        logic [4:0]  wa;
        logic        we, ld, ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clear_side();
        pc = 0; inst = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + i;
        m_reset();

        // Register values are rf[i] = A000_0000 + i.
        vecs.push_back('{32'h3401_1234, 0, 0, 0,  0, 0, 0,  OP_OR,   SEL_LOGIC, 32'h0, 32'h0000_1234, 1, 1, 0, 0});
        vecs.push_back('{32'h0022_1821, 1, 1, 5,  1, 1, 9,  OP_ADDU, SEL_ARITH, 32'h5, 32'hA000_0002, 3, 1, 0, 0});
        vecs.push_back('{32'h0022_1821, 0, 1, 5,  1, 1, 9,  OP_ADDU, SEL_ARITH, 32'h9, 32'hA000_0002, 3, 1, 0, 0});
        vecs.push_back('{32'h2422_FFFF, 0, 0, 0,  0, 0, 0,  OP_ADDU, SEL_ARITH, 32'hA000_0001, 32'hFFFF_FFFF, 2, 1, 0, 0});
        vecs.push_back('{32'h3C07_ABCD, 0, 0, 0,  0, 0, 0,  OP_OR,   SEL_LOGIC, 32'h0, 32'hABCD_0000, 7, 1, 0, 0});
        vecs.push_back('{32'h0002_20C0, 0, 0, 0,  0, 0, 0,  OP_SLL,  SEL_SHIFT, 32'h3, 32'hA000_0002, 4, 1, 0, 0});
        vecs.push_back('{32'h8C25_0008, 0, 0, 0,  0, 0, 0,  OP_LW,   SEL_LOAD,  32'hA000_0001, 32'h8, 5, 1, 1, 0});
        vecs.push_back('{32'hFC00_0000, 0, 0, 0,  0, 0, 0,  OP_NOP,  SEL_NOP,   32'h0, 32'h0, 0, 0, 0, 1});
        vecs.push_back('{32'h0000_0000, 0, 0, 0,  0, 0, 0,  OP_NOP,  SEL_NOP,   32'h0, 32'h0, 0, 0, 0, 0});
        vecs.push_back('{32'h3066_8000, 0, 0, 0,  0, 0, 0,  OP_AND,  SEL_LOGIC, 32'hA000_0003, 32'h0000_8000, 6, 1, 0, 0});
        vecs.push_back('{32'h0002_0823, 0, 0, 0,  1, 2, 32'h77, OP_SUBU, SEL_ARITH, 32'h0, 32'h77, 1, 1, 0, 0});

        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b1;

        foreach (vecs[k]) begin
            clear_side();
            inst = vecs[k].inst; pc = 32'h400 + 32'(k) * 4;
            ex_we = vecs[k].ex_we; ex_waddr = vecs[k].ex_waddr; ex_wdata = vecs[k].ex_wdata;
            mem_we = vecs[k].mem_we; mem_waddr = vecs[k].mem_waddr; mem_wdata = vecs[k].mem_wdata;
            cycle(0);
            chk($sformatf("vec%0d.id_ready", k), last_ready_a, 1);
            chk($sformatf("vec%0d.ex_valid", k), a_valid, 1);
            chk($sformatf("vec%0d.aluop", k), a_op, vecs[k].op);
            chk($sformatf("vec%0d.alusel", k), a_sel, vecs[k].sel);
            chk($sformatf("vec%0d.reg0", k), a_r0, vecs[k].r0);
            chk($sformatf("vec%0d.reg1", k), a_r1, vecs[k].r1);
            chk($sformatf("vec%0d.waddr", k), a_wa, vecs[k].wa);
            chk($sformatf("vec%0d.we", k), a_we, vecs[k].we);
            chk($sformatf("vec%0d.is_load", k), a_ld, vecs[k].ld);
            chk($sformatf("vec%0d.illegal", k), a_ill, vecs[k].ill);
            chk($sformatf("vec%0d.pc", k), a_pc, 32'h400 + 32'(k) * 4);
        end

        // Load-use: LW $4 in EX, ADDU $5,$4,$4 in ID.
        clear_side();
        inst = 32'h0084_2821; ex_is_load = 1; ex_we = 1; ex_waddr = 4; ex_wdata = 32'hDEAD;
        cycle(0);
        chk("lu.id_ready", last_ready_a, 0);
        chk("lu.bubble_valid", a_valid, 0);
        chk("lu.bubble_we", a_we, 0);
        chk("lu.bubble_aluop", a_op, OP_NOP);
        chk("lu.stall_cnt", a_cnt, 1);
        ex_is_load = 0; ex_we = 0;
        cycle(0);
        chk("lu.issue_ready", last_ready_a, 1);
        chk("lu.issue_valid", a_valid, 1);
        chk("lu.issue_waddr", a_wa, 5);
        chk("lu.issue_reg0", a_r0, 32'hA000_0004);
        chk("lu.stall_cnt_hold", a_cnt, 1);

        // Back-pressure for 3 cycles (with a hazard present), then flush.
        clear_side();
        inst = 32'h3401_1234;
        cycle(0);
        ex_ready = 0; inst = 32'h0084_2821; ex_is_load = 1; ex_we = 1; ex_waddr = 4;
        for (int i = 0; i < 3; i++) begin
            cycle(0);
            chk("bp.id_ready", last_ready_a, 0);
            chk("bp.ex_valid", a_valid, 1);
            chk("bp.aluop", a_op, OP_OR);
            chk("bp.reg1", a_r1, 32'h1234);
            chk("bp.waddr", a_wa, 1);
            chk("bp.stall_cnt", a_cnt, 1);
        end
        flush = 1;
        cycle(0);
        chk("flush.id_ready", last_ready_a, 1);
        chk("flush.ex_valid", a_valid, 0);
        chk("flush.stall_cnt", a_cnt, 1);

        // Reset in the middle of the stream.
        clear_side();
        inst = 32'h3401_1234;
        cycle(0);
        chk("mid.ex_valid_before", a_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_reset();

        // Five consecutive stall cycles: 2-bit counter saturates at 3.
        clear_side();
        inst = 32'h0084_2821; ex_is_load = 1; ex_we = 1; ex_waddr = 4;
        for (int k = 1; k <= 5; k++) begin
            cycle(0);
            chk("sat.a_cnt", a_cnt, 16'(k));
            chk("sat.b_cnt", b_cnt, (k < 3) ? 2'(k) : 2'd3);
            chk("sat.b_valid", b_valid, 0);
        end

        // Randomized traffic against the model.
        clear_side();
        do_reset();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            flush      = ($urandom_range(0, 11) == 0);
            if_valid   = ($urandom_range(0, 99) < 85);
            ex_ready   = ($urandom_range(0, 99) < 70);
            inst       = rand_inst();
            pc         = $urandom;
            ex_we      = ($urandom_range(0, 99) < 60);
            ex_is_load = ($urandom_range(0, 99) < 40);
            ex_waddr   = 5'($urandom_range(0, 3));
            ex_wdata   = $urandom;
            mem_we     = ($urandom_range(0, 99) < 60);
            mem_waddr  = 5'($urandom_range(0, 3));
            mem_wdata  = $urandom;
            cycle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
